// File: rtl/clkdiv_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Holds default widths/divisor, channel-index width and half-period helper.
package clkdiv_pkg;

  localparam int DIV_W_DFLT       = 16;
  localparam int DEFAULT_DIV_DFLT = 10;

  // Channel-select width; never zero so a 1-channel build still has a port.
  function automatic int CH_IDX_W(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // ceil(d/2) in one extra bit so d = all-ones cannot overflow.
  // Divisor widths up to 32 bits are supported.
  function automatic logic [32:0] half_up(input logic [31:0] d);
    return ({1'b0, d} + 33'd1) >> 1;
  endfunction

endpackage

// File: rtl/clkdiv_channel.sv
// One divider channel: counter, active/shadow divisor, tick and square wave.
// Ports: clk_in, rst, wr/wr_val (shadow write), sync, pending, tick, sq_out.
module clkdiv_channel
  import clkdiv_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DFLT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DFLT
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_val,
  input  logic             sync,
  output logic             pending,
  output logic             tick,
  output logic             sq_out
);

  localparam logic [DIV_W-1:0] DFLT = DIV_W'(DEFAULT_DIV);
  localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] active;
  logic [DIV_W-1:0] shadow;

  logic [DIV_W-1:0] cnt_nxt;
  logic [DIV_W-1:0] active_nxt;
  logic [DIV_W-1:0] shadow_nxt;
  logic             pending_nxt;
  logic             tick_nxt;
  logic             sq_nxt;
  logic             halted;
  logic             wrap;
  logic             apply;
  logic [32:0]      half;

  assign halted = (active == '0);
  assign wrap   = !halted && (cnt == active - ONE);

  always_comb begin
    active_nxt  = active;
    shadow_nxt  = shadow;
    pending_nxt = pending;
    cnt_nxt     = cnt + ONE;
    tick_nxt    = 1'b0;
    sq_nxt      = 1'b0;
    half        = '0;

    if (wr) begin
      shadow_nxt  = wr_val;
      pending_nxt = 1'b1;
    end

    // A halted channel takes its shadow one edge after the write;
    // a running one only at the wrap, so periods are never cut.
    apply = sync || wrap || (halted && !wr);

    if (apply && (wr || pending)) begin
      active_nxt  = wr ? wr_val : shadow;
      pending_nxt = 1'b0;
    end

    if (sync || wrap || halted) begin
      cnt_nxt = '0;
    end

    tick_nxt = wrap && !sync;
    half     = half_up(32'(active_nxt));
    sq_nxt   = (33'(cnt_nxt) < half);
  end

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      active  <= DFLT;
      shadow  <= DFLT;
      pending <= 1'b0;
      tick    <= 1'b0;
      sq_out  <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      active  <= active_nxt;
      shadow  <= shadow_nxt;
      pending <= pending_nxt;
      tick    <= tick_nxt;
      sq_out  <= sq_nxt;
    end
  end

endmodule

// File: rtl/prog_clock_divider.sv
// N-channel programmable clock divider: write decode, ack and sync fan-out.
// Ports: clk_in, rst, div_wr/div_ch/div_val, wr_ack, sync, pending, tick, sq_out.
module prog_clock_divider
  import clkdiv_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int DIV_W       = DIV_W_DFLT,
  parameter int DEFAULT_DIV = DEFAULT_DIV_DFLT
) (
  input  logic                      clk_in,
  input  logic                      rst,
  input  logic                      div_wr,
  input  logic [CH_IDX_W(N_CH)-1:0] div_ch,
  input  logic [DIV_W-1:0]          div_val,
  output logic                      wr_ack,
  input  logic                      sync,
  output logic [N_CH-1:0]           pending,
  output logic [N_CH-1:0]           tick,
  output logic [N_CH-1:0]           sq_out
);

  localparam int CW = CH_IDX_W(N_CH);

  logic [N_CH-1:0] wr_sel;

  // Ack any strobe, including out-of-range channel indices.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      wr_ack <= 1'b0;
    end else begin
      wr_ack <= div_wr;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    assign wr_sel[i] = div_wr && (div_ch == CW'(i));

    clkdiv_channel #(
      .DIV_W       (DIV_W),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_ch (
      .clk_in  (clk_in),
      .rst     (rst),
      .wr      (wr_sel[i]),
      .wr_val  (div_val),
      .sync    (sync),
      .pending (pending[i]),
      .tick    (tick[i]),
      .sq_out  (sq_out[i])
    );
  end

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed self-checking bench for prog_clock_divider (4 ch, 16-bit, div 10).
// Edge counter e tracks rising edges since the last reset release.
module tb_prog_clock_divider;

  logic        clk_in  = 1'b0;
  logic        rst     = 1'b1;
  logic        div_wr  = 1'b0;
  logic [1:0]  div_ch  = 2'd0;
  logic [15:0] div_val = 16'd0;
  logic        sync    = 1'b0;
  logic        wr_ack;
  logic [3:0]  pending;
  logic [3:0]  tick;
  logic [3:0]  sq_out;

  int checks = 0;
  int errors = 0;
  int e      = 0;

  always #5 clk_in = ~clk_in;

  prog_clock_divider #(
    .N_CH        (4),
    .DIV_W       (16),
    .DEFAULT_DIV (10)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .div_wr  (div_wr),
    .div_ch  (div_ch),
    .div_val (div_val),
    .wr_ack  (wr_ack),
    .sync    (sync),
    .pending (pending),
    .tick    (tick),
    .sq_out  (sq_out)
  );

  task automatic step();
    @(posedge clk_in);
    #1;
    e++;
  endtask

  task automatic wr(input int ch, input int val);
    div_wr  = 1'b1;
    div_ch  = 2'(ch);
    div_val = 16'(val);
  endtask

  task automatic test_reset();
    logic [3:0] et;
    logic [3:0] es;
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({tick, sq_out, pending, wr_ack} !== 13'b0) begin
      errors++;
      $display("FAIL reset_state: tick=%b sq=%b pend=%b ack=%b, want 0",
               tick, sq_out, pending, wr_ack);
    end
    rst = 1'b0;
    e = 0;
    while (e < 200) begin
      step();
      et = (e % 10 == 0) ? 4'hF : 4'h0;
      es = (e % 10 < 5) ? 4'hF : 4'h0;
      checks++;
      if (tick !== et || sq_out !== es || pending !== 4'h0) begin
        errors++;
        $display("FAIL default_div e=%0d: tick=%b sq=%b pend=%b, want %b %b 0000",
                 e, tick, sq_out, pending, et, es);
      end
    end
  endtask

  task automatic test_write_mid();
    logic et, es, ep;
    int c;
    step();
    step();
    step();
    wr(1, 7);
    step();
    div_wr = 1'b0;
    checks++;
    if (wr_ack !== 1'b1 || pending !== 4'b0010) begin
      errors++;
      $display("FAIL write_ack: ack=%b pend=%b, want 1 0010", wr_ack, pending);
    end
    while (e < 240) begin
      step();
      if (e < 210) begin
        c = e % 10;
        et = 1'b0;
        es = (c < 5);
        ep = 1'b1;
      end else begin
        c = (e - 210) % 7;
        et = (c == 0);
        es = (c < 4);
        ep = 1'b0;
      end
      checks++;
      if (tick[1] !== et || sq_out[1] !== es || pending[1] !== ep ||
          wr_ack !== 1'b0) begin
        errors++;
        $display("FAIL write_mid e=%0d: tick=%b sq=%b pend=%b ack=%b, want %b %b %b 0",
                 e, tick[1], sq_out[1], pending[1], wr_ack, et, es, ep);
      end
    end
  endtask

  task automatic test_halt();
    logic et, es, ep;
    int c;
    wr(2, 0);
    step();
    div_wr = 1'b0;
    while (e < 255) begin
      step();
      et = (e == 250);
      es = (e < 250) ? (e % 10 < 5) : 1'b0;
      ep = (e < 250);
      checks++;
      if (tick[2] !== et || sq_out[2] !== es || pending[2] !== ep) begin
        errors++;
        $display("FAIL halt e=%0d: tick=%b sq=%b pend=%b, want %b %b %b",
                 e, tick[2], sq_out[2], pending[2], et, es, ep);
      end
    end
    wr(2, 3);
    step();
    div_wr = 1'b0;
    checks++;
    if (pending[2] !== 1'b1 || tick[2] !== 1'b0 || sq_out[2] !== 1'b0) begin
      errors++;
      $display("FAIL halt_write: pend=%b tick=%b sq=%b, want 1 0 0",
               pending[2], tick[2], sq_out[2]);
    end
    while (e < 275) begin
      step();
      c = (e - 257) % 3;
      et = (e > 257) && (c == 0);
      es = (c < 2);
      checks++;
      if (tick[2] !== et || sq_out[2] !== es || pending[2] !== 1'b0) begin
        errors++;
        $display("FAIL unhalt e=%0d: tick=%b sq=%b pend=%b, want %b %b 0",
                 e, tick[2], sq_out[2], pending[2], et, es);
      end
    end
  endtask

  task automatic test_last_wins();
    logic et, es, ep;
    int c;
    wr(0, 20);
    step();
    div_wr = 1'b0;
    step();
    wr(0, 4);
    step();
    div_wr = 1'b0;
    checks++;
    if (pending[0] !== 1'b1 || tick[0] !== 1'b0) begin
      errors++;
      $display("FAIL overwrite_pend: pend=%b tick=%b, want 1 0",
               pending[0], tick[0]);
    end
    while (e < 300) begin
      step();
      if (e < 280) begin
        et = 1'b0;
        es = (e % 10 < 5);
        ep = 1'b1;
      end else begin
        c = (e - 280) % 4;
        et = (c == 0);
        es = (c < 2);
        ep = 1'b0;
      end
      checks++;
      if (tick[0] !== et || sq_out[0] !== es || pending[0] !== ep) begin
        errors++;
        $display("FAIL last_wins e=%0d: tick=%b sq=%b pend=%b, want %b %b %b",
                 e, tick[0], sq_out[0], pending[0], et, es, ep);
      end
    end
  endtask

  task automatic test_sync();
    int dv [4];
    logic [3:0] et;
    logic [3:0] es;
    int c;
    dv = '{10, 7, 3, 1};
    wr(0, 10);
    step();
    div_wr = 1'b0;
    checks++;
    if (pending !== 4'b0001) begin
      errors++;
      $display("FAIL sync_pre: pend=%b, want 0001", pending);
    end
    wr(3, 1);
    sync = 1'b1;
    step();
    div_wr = 1'b0;
    checks++;
    if (tick !== 4'h0 || sq_out !== 4'hF || pending !== 4'h0 || wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL sync_edge: tick=%b sq=%b pend=%b ack=%b, want 0000 1111 0000 1",
               tick, sq_out, pending, wr_ack);
    end
    for (int h = 0; h < 2; h++) begin
      step();
      checks++;
      if (tick !== 4'h0 || sq_out !== 4'hF) begin
        errors++;
        $display("FAIL sync_hold e=%0d: tick=%b sq=%b, want 0000 1111",
                 e, tick, sq_out);
      end
    end
    sync = 1'b0;
    while (e < 330) begin
      step();
      for (int i = 0; i < 4; i++) begin
        c = (e - 304) % dv[i];
        et[i] = (c == 0);
        es[i] = (c < (dv[i] + 1) / 2);
      end
      checks++;
      if (tick !== et || sq_out !== es || pending !== 4'h0) begin
        errors++;
        $display("FAIL sync_align e=%0d: tick=%b sq=%b pend=%b, want %b %b 0000",
                 e, tick, sq_out, pending, et, es);
      end
    end
  endtask

  task automatic test_reset_async();
    logic [3:0] et;
    logic [3:0] es;
    wr(1, 5);
    step();
    div_wr = 1'b0;
    checks++;
    if (pending !== 4'b0010 || wr_ack !== 1'b1) begin
      errors++;
      $display("FAIL prereset: pend=%b ack=%b, want 0010 1", pending, wr_ack);
    end
    #3;
    rst = 1'b1;
    #1;
    checks++;
    if ({tick, sq_out, pending, wr_ack} !== 13'b0) begin
      errors++;
      $display("FAIL async_reset: tick=%b sq=%b pend=%b ack=%b, want 0",
               tick, sq_out, pending, wr_ack);
    end
    step();
    step();
    rst = 1'b0;
    e = 0;
    while (e < 30) begin
      step();
      et = (e % 10 == 0) ? 4'hF : 4'h0;
      es = (e % 10 < 5) ? 4'hF : 4'h0;
      checks++;
      if (tick !== et || sq_out !== es || pending !== 4'h0) begin
        errors++;
        $display("FAIL after_reset e=%0d: tick=%b sq=%b pend=%b, want %b %b 0000",
                 e, tick, sq_out, pending, et, es);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write_mid();
    test_halt();
    test_last_wins();
    test_sync();
    test_reset_async();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
